bm_dag3_lpm_stim_chk: RTL and testbench

- Self-checking stimulus driver and response checker for the 2-operand DAG micro benchmark (`out = a|b|c|d`, with `c=~a_in`, `a=b_in+c`, `b=a_in^c`, `d=b-b_in`).
- Exhaustively sweeps every `(a_in, b_in)` pair into the DUT and compares each response against an internal golden model.
- Counts mismatches and reports pass/fail. Sits beside the DUT in the regression harness, owning the DUT's input side and observing its output.

---
 rtl/bm_dag3_lpm_stim_chk.sv | 175 +++++++++++++++++
 tb/tb_bm_dag3_lpm_stim_chk.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bm_dag3_lpm_stim_chk.sv
// Purpose: exhaustive stimulus driver and response checker for the DAG micro benchmark.
// Latency: one vector per cycle; each response is compared LATENCY cycles after its vector.
// Backpressure: none; start is ignored while busy, and the sweep runs at full rate once begun.
//
// Ports:
//   clock, reset     - rising-edge clock, asynchronous active-high reset
//   start            - one-cycle sweep request, honoured in IDLE or DONE
//   a_out, b_out     - registered operands driven into the DUT
//   dut_out          - DUT response
//   busy, done, pass - sweep status; pass only in DONE with no mismatches
//   err_count        - saturating mismatch count
//   fail_a, fail_b   - first failing operand pair
// Optional feature: BM_DAG3_STIM_CHK_FIRST_FAIL_EN builds the first-fail capture
// registers; without it fail_a/fail_b are tied to 0.

module bm_dag3_lpm_stim_chk #(
   parameter int BITS    = 2,
   parameter int LATENCY = 0,
   parameter int ERRW    = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   output logic [BITS-1:0] a_out,
   output logic [BITS-1:0] b_out,
   input  logic [BITS-1:0] dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_count,
   output logic [BITS-1:0] fail_a,
   output logic [BITS-1:0] fail_b
);

   localparam int IW = 2 * BITS;
   localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef BM_DAG3_STIM_CHK_FIRST_FAIL_EN
   // The operand pair only needs to travel with exp when it can be captured.
   localparam int PW = 3 * BITS;
`else
   localparam int PW = BITS;
`endif

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   idx;
   logic            pres_vld;
   logic [DW-1:0]   drain_cnt;
   logic            last_vec;
   logic            drain_last;
   logic            launch;
   logic [BITS-1:0] c_g, s_g, x_g, d_g, exp_g;
   logic [PW-1:0]   pres_dat, chk_dat;
   logic            chk_vld;
   logic            mismatch;

   // Explicit last-vector flag; the idx wrap is never used to terminate.
   assign last_vec   = (idx == {IW{1'b1}});
   assign drain_last = (drain_cnt == DW'(LATENCY - 1));
   assign launch     = start && ((state == IDLE) || (state == DONE));

   // idx is registered, so the operands are registered too.
   assign a_out = idx[IW-1:BITS];
   assign b_out = idx[BITS-1:0];

   // Golden model of the presented vector, mod 2^BITS.
   always_comb begin
      c_g   = ~a_out;
      s_g   = b_out + c_g;
      x_g   = a_out ^ c_g;
      d_g   = x_g - b_out;
      exp_g = s_g | x_g | c_g | d_g;
   end

`ifdef BM_DAG3_STIM_CHK_FIRST_FAIL_EN
   assign pres_dat = {a_out, b_out, exp_g};
`else
   assign pres_dat = exp_g;
`endif

   // ---------------- state machine ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = SWEEP;
         SWEEP:      if (last_vec) state_nxt = (LATENCY > 0) ? DRAIN : DONE;
         DRAIN:      if (drain_last) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   assign busy = (state == SWEEP) || (state == DRAIN);
   assign done = (state == DONE);
   assign pass = done && (err_count == '0);

   // ---------------- vector sequencer ----------------
   // pres_vld is high exactly during the cycles that present vectors 0..N-1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         pres_vld  <= 1'b0;
         drain_cnt <= '0;
      end else begin
         pres_vld <= 1'b0;
         if (launch) begin
            idx      <= '0;
            pres_vld <= 1'b1;
         end else if ((state == SWEEP) && !last_vec) begin
            idx      <= idx + IW'(1);
            pres_vld <= 1'b1;
         end
         if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
         else                drain_cnt <= '0;
      end
   end

   // ---------------- check pipeline ----------------
   generate
      if (LATENCY == 0) begin : g_nodly
         assign chk_vld = pres_vld;
         assign chk_dat = pres_dat;
      end else begin : g_dly
         logic [LATENCY-1:0] vld_sr;
         logic [PW-1:0]      dat_sr [LATENCY];
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               vld_sr <= '0;
               for (int i = 0; i < LATENCY; i++) dat_sr[i] <= '0;
            end else begin
               vld_sr[0] <= pres_vld;
               dat_sr[0] <= pres_dat;
               for (int i = 1; i < LATENCY; i++) begin
                  vld_sr[i] <= vld_sr[i-1];
                  dat_sr[i] <= dat_sr[i-1];
               end
            end
         end
         assign chk_vld = vld_sr[LATENCY-1];
         assign chk_dat = dat_sr[LATENCY-1];
      end
   endgenerate

   assign mismatch = chk_vld && (dut_out != chk_dat[BITS-1:0]);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                              err_count <= '0;
      else if (launch)                        err_count <= '0;
      else if (mismatch && (err_count != '1)) err_count <= err_count + ERRW'(1);
   end

`ifdef BM_DAG3_STIM_CHK_FIRST_FAIL_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fail_a <= '0;
         fail_b <= '0;
      end else if (launch) begin
         fail_a <= '0;
         fail_b <= '0;
      end else if (mismatch && (err_count == '0)) begin
         fail_a <= chk_dat[3*BITS-1:2*BITS];
         fail_b <= chk_dat[2*BITS-1:BITS];
      end
   end
`else
   assign fail_a = '0;
   assign fail_b = '0;
`endif

endmodule

// File: tb/tb_bm_dag3_lpm_stim_chk.sv
// Purpose: bench for bm_dag3_lpm_stim_chk with a combinational and a two-stage DUT model.
// Latency: checks vector timing, done timing and final results for LATENCY 0 and 2.
// Backpressure: exercises start while busy, restart from DONE and reset mid-sweep.

module tb_bm_dag3_lpm_stim_chk;

`ifdef BM_DAG3_STIM_CHK_FIRST_FAIL_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0, start1 = 1'b0;
   int         fault = 0;
   bit         lsel = 1'b0;

   logic [1:0] a0, b0, dout0, fa0, fb0;
   logic [1:0] a1, b1, dout1, fa1, fb1;
   logic       busy0, done0, pass0, busy1, done1, pass1;
   logic [7:0] err0, err1;
   logic [1:0] r1, r2;

   always #5 clk = ~clk;

   // DUT behaviour with optional injected faults.
   function automatic logic [1:0] dag(input logic [1:0] ai, input logic [1:0] bi, input int f);
      logic [1:0] c, a, b, d, o;
      c = ~ai;
      a = bi + c;
      b = ai ^ c;
      d = b - bi;
      o = a | b | c | d;
      if (f == 1) o[0] = 1'b0;
      if (f == 2 && ai == 2'd2 && bi == 2'd1) o = 2'b01;
      if (f == 3 && ai == 2'd1 && bi == 2'd1) o = 2'b10;
      return o;
   endfunction

   assign dout0 = dag(a0, b0, fault);
   always @(posedge clk) begin
      r1 <= dag(a1, b1, fault);
      r2 <= r1;
   end
   assign dout1 = r2;

   bm_dag3_lpm_stim_chk #(.BITS(2), .LATENCY(0), .ERRW(8)) u_l0 (
      .clock(clk), .reset(rst), .start(start0), .a_out(a0), .b_out(b0),
      .dut_out(dout0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_a(fa0), .fail_b(fb0));

   bm_dag3_lpm_stim_chk #(.BITS(2), .LATENCY(2), .ERRW(8)) u_l2 (
      .clock(clk), .reset(rst), .start(start1), .a_out(a1), .b_out(b1),
      .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_a(fa1), .fail_b(fb1));

   logic [1:0] s_a, s_b, s_fa, s_fb;
   logic       s_busy, s_done, s_pass;
   logic [7:0] s_err;
   assign s_a    = lsel ? a1 : a0;
   assign s_b    = lsel ? b1 : b0;
   assign s_fa   = lsel ? fa1 : fa0;
   assign s_fb   = lsel ? fb1 : fb0;
   assign s_busy = lsel ? busy1 : busy0;
   assign s_done = lsel ? done1 : done0;
   assign s_pass = lsel ? pass1 : pass0;
   assign s_err  = lsel ? err1 : err0;

   typedef struct {
      int         lat;
      int         fault;
      int         exp_err;
      bit         exp_pass;
      logic [1:0] exp_fa;
      logic [1:0] exp_fb;
      int         exp_done;
      bit         busy_pulse;
   } rec_t;

   rec_t tbl [6];
   int   vq [$];
   rec_t rq [$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pulse_start();
      if (lsel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic run(input rec_t r);
      int n;
      bit got;
      rec_t rr;
      fault = r.fault;
      lsel  = (r.lat == 2);
      @(negedge clk);
      for (int k = 0; k < 16; k++) vq.push_back(k);
      rq.push_back(r);
      pulse_start();                 // now just after E0 (n = 0)
      check("busy_after_start", s_busy, 1);
      check("err_cleared", s_err, 0);
      n = 0;
      got = 1'b0;
      while (n < 100) begin
         if (n < 16) check("vector", {s_a, s_b}, vq.pop_front());
         if (r.busy_pulse && n == 5) begin
            if (lsel) start1 = 1'b1; else start0 = 1'b1;
         end
         if (n == 6) begin
            start0 = 1'b0;
            start1 = 1'b0;
         end
         if (s_done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         n++;
      end
      vq.delete();
      check("done_seen", got, 1);
      check("done_cycle", n, r.exp_done);
      rr = rq.pop_front();
      check("err_count", s_err, rr.exp_err);
      check("pass", s_pass, rr.exp_pass);
      check("fail_a", s_fa, rr.exp_fa);
      check("fail_b", s_fb, rr.exp_fb);
      check("busy_in_done", s_busy, 0);
      check("hold_last_vec", {s_a, s_b}, 15);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //          lat flt err pass fa                 fb                 done bp
      tbl[0] = '{0, 0, 0,  1'b1, 2'd0,              2'd0,              16, 1'b0};
      tbl[1] = '{0, 1, 16, 1'b0, 2'd0,              2'd0,              16, 1'b0};
      tbl[2] = '{0, 2, 1,  1'b0, CAP ? 2'd2 : 2'd0, CAP ? 2'd1 : 2'd0, 16, 1'b0};
      tbl[3] = '{0, 0, 0,  1'b1, 2'd0,              2'd0,              16, 1'b0};
      tbl[4] = '{2, 0, 0,  1'b1, 2'd0,              2'd0,              18, 1'b0};
      tbl[5] = '{2, 3, 1,  1'b0, CAP ? 2'd1 : 2'd0, CAP ? 2'd1 : 2'd0, 18, 1'b1};

      // Reset state of both instances.
      #3;
      check("rst_l0_outs", {a0, b0, busy0, done0, pass0, fa0, fb0}, 0);
      check("rst_l0_err", err0, 0);
      check("rst_l2_outs", {a1, b1, busy1, done1, pass1, fa1, fb1}, 0);
      check("rst_l2_err", err1, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_no_busy", busy0, 0);

      for (int i = 0; i < 6; i++) run(tbl[i]);

      // Reset during vector 7 aborts at once.
      fault = 1;
      lsel  = 1'b0;
      @(negedge clk);
      pulse_start();
      repeat (7) @(negedge clk);
      check("mid_vector", {a0, b0}, 7);
      check("mid_err", err0, 7);
      rst = 1'b1;
      #1;
      check("abort_outs", {a0, b0, busy0, done0, pass0, fa0, fb0}, 0);
      check("abort_err", err0, 0);
      @(negedge clk);
      rst = 1'b0;
      run(tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
